alu: RTL
========

Name: alu

Overview:
- Arithmetic/logic unit directly downstream of the CPU.
- Consumes the alu_op command issued by the CPU each cycle.
- Holds the datapath registers A, B, ACC and INDEX plus status flags.
- Returns ACC to the shared databus on request, and returns INDEX and flags to the CPU for indexed addressing and conditional jumps.

Parameters:
- DATA_WIDTH, 8, datapath width; only 8 is supported (ASCII conversion assumes bytes).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- ALU_op  in  5  command; type global_pkg::alu_op.
- InData  in  8  databus value, used by op_lda/op_ldb/op_ldacc/op_ldid.
- OutData  out  8  equals ACC whenever OutEn=1, else 8'h00.
- OutEn  out  1  high in any cycle where ALU_op==op_oeacc (combinational).
- Index  out  8  INDEX register.
- FlagZ  out  1  zero / compare-true.
- FlagC  out  1  carry (add) / shifted-out bit.
- FlagB  out  1  borrow (sub).
- FlagN  out  1  result bit 7.
- FlagE  out  1  conversion error.

Behaviour:
- Reset (async, Rst=1): A, B, ACC, INDEX = 8'h00; all flags = 0; OutEn = 0, OutData = 8'h00.
- Timing: ALU_op sampled at every rising Clk. Register/flag updates are visible the cycle after the command. Back-to-back commands see the previous command's result with no stall.
- Loads:
  - op_lda/op_ldb/op_ldacc/op_ldid write InData to A/B/ACC/INDEX.
  - op_mvacc2id/op_mvacc2a/op_mvacc2b copy ACC to INDEX/A/B.
  - Flags are unchanged by loads and moves.
- nop, and encodings 21..31: no state change.
- op_add: {C,ACC} = A+B, 9-bit sum. Z = (ACC==0). N = ACC[7].
- op_sub: ACC = A-B mod 256. B = (A<B). Z and N set as for add. C unchanged.
- op_shiftl: ACC = {A[6:0],0}, C = A[7]. op_shiftr: ACC = {0,A[7:1]}, C = A[0]. Both update Z and N.
- op_and/op_or/op_xor: ACC = A op B. Update Z and N. C and B cleared.
- Compares (ACC and other flags unchanged):
  - op_cmpe: Z = (A==B).
  - op_cmpl: Z = (A<B), unsigned.
  - op_cmpg: Z = (A>B), unsigned.
- op_ascii2bin:
  - A in 8'h30..8'h39 -> ACC = A-8'h30.
  - A in 8'h41..8'h46 -> ACC = A-8'h37.
  - Otherwise ACC = 8'hFF.
  - E = 1 on error, else 0.
- op_bin2ascii:
  - A <= 9 -> ACC = A+8'h30.
  - A in 10..15 -> ACC = A+8'h37.
  - A > 15 -> ACC = 8'hFF, E = 1.
  - E = 0 on success.
- op_oeacc: OutEn = 1 and OutData = current ACC in the same cycle. No register change.
- FlagE is sticky across non-conversion ops and is only rewritten by a conversion op.
- Reset mid-sequence: all state returns to reset values immediately. The next command after Rst falls executes normally.
- Wrap: add 8'hFF+8'h01 -> ACC = 0, C = 1, Z = 1. Sub 8'h00-8'h01 -> ACC = 8'hFF, B = 1, N = 1.

Decomposition:
- global_pkg holds:
  - the existing alu_op typedef;
  - new ASCII constants: ASCII_0 = 'h30, ASCII_A = 'h41, ASCII_F = 'h46, ALU_CONV_ERR = 'hFF.
- One combinational sub-module: alu_ascii_conv (inputs A and direction; outputs result and error). The alu instantiates it once.
- All registers live in alu.

Test Plan:
- Reset during traffic: load A = 8'h55, assert Rst mid-cycle -> all outputs 0 asynchronously; op_oeacc after release -> OutData = 8'h00, OutEn = 1.
- Add: lda 8'hFF, ldb 8'h01, op_add -> next cycle ACC = 0, C = 1, Z = 1. Then op_oeacc -> OutData = 8'h00.
- Sub and compares: A = 8'h03, B = 8'h05; op_sub -> ACC = 8'hFE, B = 1, N = 1. op_cmpl -> Z = 1. op_cmpg -> Z = 0. op_cmpe -> Z = 0, ACC still 8'hFE.
- ASCII conversion:
  - A = 8'h43: op_ascii2bin -> ACC = 8'h0C, E = 0.
  - A = 8'h47: op_ascii2bin -> ACC = 8'hFF, E = 1; E remains 1 through a following op_add.
  - A = 8'h0B: op_bin2ascii -> ACC = 8'h42, E = 0.
- Moves and index: ldacc 8'h40, op_mvacc2id -> Index = 8'h40 next cycle, flags unchanged. Back-to-back op_mvacc2a then op_shiftl -> ACC = 8'h80, C = 0, N = 1.
- Illegal ops: drive encodings 21..31 for 11 cycles -> no register or flag change; OutEn = 0.

Source files
------------

// File: rtl/global_pkg.sv
// Shared definitions for the CPU/ALU pair.
//   alu_op       : 5-bit command issued by the CPU to the ALU each cycle.
//                  Encodings 21..31 are unassigned and behave as nop.
//   ASCII_*      : character codes used by the ASCII <-> binary conversions.
//   ALU_CONV_ERR : value written to ACC when a conversion fails.
package global_pkg;

    typedef enum logic [4:0] {
        op_nop        = 5'd0,
        op_lda        = 5'd1,
        op_ldb        = 5'd2,
        op_ldacc      = 5'd3,
        op_ldid       = 5'd4,
        op_mvacc2id   = 5'd5,
        op_mvacc2a    = 5'd6,
        op_mvacc2b    = 5'd7,
        op_add        = 5'd8,
        op_sub        = 5'd9,
        op_shiftl     = 5'd10,
        op_shiftr     = 5'd11,
        op_and        = 5'd12,
        op_or         = 5'd13,
        op_xor        = 5'd14,
        op_cmpe       = 5'd15,
        op_cmpl       = 5'd16,
        op_cmpg       = 5'd17,
        op_ascii2bin  = 5'd18,
        op_bin2ascii  = 5'd19,
        op_oeacc      = 5'd20
    } alu_op;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_F      = 8'h46;
    localparam logic [7:0] ALU_CONV_ERR = 8'hFF;

    // Sign bit of a byte result; drives the N flag.
    function automatic logic msb8(input logic [7:0] v);
        return v[7];
    endfunction

endpackage

// File: rtl/alu_ascii_conv.sv
// Combinational ASCII <-> binary converter for one hex digit.
//   a        : input byte (register A)
//   to_ascii : 1 = binary nibble to ASCII hex digit, 0 = ASCII hex digit to binary
//   result   : converted value, or ALU_CONV_ERR when the input is out of range
//   err      : 1 when the input cannot be converted
// Only upper-case 'A'..'F' are accepted as hex letters.
module alu_ascii_conv
    import global_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  to_ascii,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);

    always_comb begin
        result = ALU_CONV_ERR;
        err    = 1'b1;
        if (to_ascii) begin
            if (a <= 8'd9) begin
                result = a + ASCII_0;
                err    = 1'b0;
            end else if (a <= 8'd15) begin
                // 10 maps onto 'A'
                result = a - 8'd10 + ASCII_A;
                err    = 1'b0;
            end
        end else begin
            if (a >= ASCII_0 && a <= ASCII_0 + 8'd9) begin
                result = a - ASCII_0;
                err    = 1'b0;
            end else if (a >= ASCII_A && a <= ASCII_F) begin
                result = a - ASCII_A + 8'd10;
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu.sv
// Arithmetic/logic unit sitting directly behind the CPU.
//   Clk     : system clock, rising edge
//   Rst     : asynchronous active-high reset
//   ALU_op  : command for this cycle (global_pkg::alu_op)
//   InData  : databus value for the load commands
//   OutData : ACC while OutEn is high, otherwise 8'h00
//   OutEn   : high during any cycle carrying op_oeacc (combinational)
//   Index   : INDEX register, used by the CPU for indexed addressing
//   FlagZ   : zero / compare-true
//   FlagC   : carry out of add, or bit shifted out
//   FlagB   : borrow out of sub
//   FlagN   : bit 7 of the last arithmetic/logic result
//   FlagE   : conversion error, held until the next conversion
// Every command completes in one cycle; results are visible the cycle after.
module alu
    import global_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  alu_op                 ALU_op,
    input  logic [DATA_WIDTH-1:0] InData,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutEn,
    output logic [DATA_WIDTH-1:0] Index,
    output logic                  FlagZ,
    output logic                  FlagC,
    output logic                  FlagB,
    output logic                  FlagN,
    output logic                  FlagE
);

    logic [DATA_WIDTH-1:0] a_q, b_q, acc_q, idx_q;
    logic [DATA_WIDTH-1:0] a_d, b_d, acc_d, idx_d;
    logic                  z_q, c_q, bf_q, n_q, e_q;
    logic                  z_d, c_d, bf_d, n_d, e_d;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] conv_result;
    logic                  conv_err;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = a_q - b_q;

    alu_ascii_conv #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_conv (
        .a        (a_q),
        .to_ascii (ALU_op == op_bin2ascii),
        .result   (conv_result),
        .err      (conv_err)
    );

    // Next-state decode; anything not listed (nop, 21..31, oeacc) holds state.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        idx_d = idx_q;
        z_d   = z_q;
        c_d   = c_q;
        bf_d  = bf_q;
        n_d   = n_q;
        e_d   = e_q;
        case (ALU_op)
            op_lda:      a_d   = InData;
            op_ldb:      b_d   = InData;
            op_ldacc:    acc_d = InData;
            op_ldid:     idx_d = InData;
            op_mvacc2id: idx_d = acc_q;
            op_mvacc2a:  a_d   = acc_q;
            op_mvacc2b:  b_d   = acc_q;
            op_add: begin
                acc_d = sum[DATA_WIDTH-1:0];
                c_d   = sum[DATA_WIDTH];
                z_d   = (sum[DATA_WIDTH-1:0] == '0);
                n_d   = msb8(sum[DATA_WIDTH-1:0]);
            end
            op_sub: begin
                acc_d = diff;
                bf_d  = (a_q < b_q);
                z_d   = (diff == '0);
                n_d   = msb8(diff);
            end
            op_shiftl: begin
                acc_d = {a_q[DATA_WIDTH-2:0], 1'b0};
                c_d   = a_q[DATA_WIDTH-1];
                z_d   = (a_q[DATA_WIDTH-2:0] == '0);
                n_d   = a_q[DATA_WIDTH-2];
            end
            op_shiftr: begin
                acc_d = {1'b0, a_q[DATA_WIDTH-1:1]};
                c_d   = a_q[0];
                z_d   = (a_q[DATA_WIDTH-1:1] == '0);
                n_d   = 1'b0;
            end
            op_and: begin
                acc_d = a_q & b_q;
                z_d   = ((a_q & b_q) == '0);
                n_d   = msb8(a_q & b_q);
                c_d   = 1'b0;
                bf_d  = 1'b0;
            end
            op_or: begin
                acc_d = a_q | b_q;
                z_d   = ((a_q | b_q) == '0);
                n_d   = msb8(a_q | b_q);
                c_d   = 1'b0;
                bf_d  = 1'b0;
            end
            op_xor: begin
                acc_d = a_q ^ b_q;
                z_d   = ((a_q ^ b_q) == '0);
                n_d   = msb8(a_q ^ b_q);
                c_d   = 1'b0;
                bf_d  = 1'b0;
            end
            op_cmpe: z_d = (a_q == b_q);
            op_cmpl: z_d = (a_q < b_q);
            op_cmpg: z_d = (a_q > b_q);
            op_ascii2bin, op_bin2ascii: begin
                acc_d = conv_result;
                e_d   = conv_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            idx_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            bf_q  <= 1'b0;
            n_q   <= 1'b0;
            e_q   <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            z_q   <= z_d;
            c_q   <= c_d;
            bf_q  <= bf_d;
            n_q   <= n_d;
            e_q   <= e_d;
        end
    end

    // Bus drive is gated by reset so the databus is released immediately.
    assign OutEn   = !Rst && (ALU_op == op_oeacc);
    assign OutData = OutEn ? acc_q : '0;
    assign Index   = idx_q;
    assign FlagZ   = z_q;
    assign FlagC   = c_q;
    assign FlagB   = bf_q;
    assign FlagN   = n_q;
    assign FlagE   = e_q;

endmodule
